// File: rtl/pong_pkg.sv
// pong_pkg: shared match-state, winner and player codes for the ping-pong match controller.
package pong_pkg;
    typedef enum logic [1:0] {
        ATTRACT  = 2'd0,
        SERVE    = 2'd1,
        RALLY    = 2'd2,
        GAMEOVER = 2'd3
    } match_state_e;
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;
endpackage

// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: button/point inputs and score/display outputs of the match controller.
interface pong_match_ctrl_if #(parameter int SCORE_W = 4);
    logic               start;
    logic               point_p1;
    logic               point_p2;
    logic [SCORE_W-1:0] sc1;
    logic [SCORE_W-1:0] sc2;
    logic               start_o;
    logic               reset_game;
    logic               serve_p;
    logic [1:0]         winner;
    modport master (
        output start, point_p1, point_p2,
        input  sc1, sc2, start_o, reset_game, serve_p, winner
    );
    modport slave (
        input  start, point_p1, point_p2,
        output sc1, sc2, start_o, reset_game, serve_p, winner
    );
endinterface

// File: rtl/pong_score_ctr.sv
// pong_score_ctr: per-player score counter with sync clear, load and increment.
module pong_score_ctr #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (rst || clr) ? '0 : ld ? d : inc ? q + 1'b1 : q;
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: attract/serve/rally/gameover sequencing, scoring, win detection and winner hold.
// Define WIN_BY_TWO_EN to require a two-point lead, with deuce normalisation.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int SERVE_DELAY = 50,
    parameter int HOLD_CYCLES = 200
) (
    input  logic            clk,
    input  logic            reset,
    pong_match_ctrl_if.slave bus
);
    localparam logic [1:0] S_ATTRACT  = ATTRACT;
    localparam logic [1:0] S_SERVE    = SERVE;
    localparam logic [1:0] S_RALLY    = RALLY;
    localparam logic [1:0] S_GAMEOVER = GAMEOVER;
    localparam int TMAX = SERVE_DELAY > HOLD_CYCLES ? SERVE_DELAY : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [1:0]         state, state_nx;
    logic [TW-1:0]      timer;
    logic [SCORE_W-1:0] sc1, sc2, n1, n2;
    logic               start_acc, p1_pt, p2_pt, replay, deuce, win1, win2, go_serve, timer_done;
    logic               serve_p, reset_game, start_o;
    logic [1:0]         winner;

    always_comb begin
        start_acc  = state == S_ATTRACT && bus.start;
        p1_pt      = state == S_RALLY && bus.point_p1 && !bus.point_p2;
        p2_pt      = state == S_RALLY && bus.point_p2 && !bus.point_p1;
        replay     = state == S_RALLY && bus.point_p1 && bus.point_p2;
        n1         = sc1 + SCORE_W'(p1_pt);
        n2         = sc2 + SCORE_W'(p2_pt);
`ifdef WIN_BY_TWO_EN
        deuce      = (p1_pt || p2_pt) && n1 == n2 && int'(n1) >= WIN_SCORE;
        win1       = p1_pt && int'(n1) >= WIN_SCORE && int'(n1) >= int'(n2) + 2;
        win2       = p2_pt && int'(n2) >= WIN_SCORE && int'(n2) >= int'(n1) + 2;
`else
        deuce      = 1'b0;
        win1       = p1_pt && int'(n1) == WIN_SCORE;
        win2       = p2_pt && int'(n2) == WIN_SCORE;
`endif
        go_serve   = start_acc || replay || ((p1_pt || p2_pt) && !win1 && !win2);
        timer_done = timer == (state == S_SERVE ? TW'(SERVE_DELAY - 1) : TW'(HOLD_CYCLES - 1));
        state_nx   = go_serve ? S_SERVE :
                     (win1 || win2) ? S_GAMEOVER :
                     (timer_done && state == S_SERVE) ? S_RALLY :
                     (timer_done && state == S_GAMEOVER) ? S_ATTRACT : state;
    end

    // Timer only advances inside the two timed states and restarts on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ATTRACT;
            timer      <= '0;
            serve_p    <= PLAYER_1;
            reset_game <= 1'b0;
            start_o    <= 1'b1;
            winner     <= WIN_NONE;
        end else begin
            state      <= state_nx;
            timer      <= (state_nx == state && (state == S_SERVE || state == S_GAMEOVER)) ? timer + 1'b1 : '0;
            serve_p    <= start_acc ? PLAYER_1 : p1_pt ? PLAYER_1 : p2_pt ? PLAYER_2 : serve_p;
            reset_game <= go_serve;
            start_o    <= state_nx == S_ATTRACT;
            winner     <= start_acc ? WIN_NONE : win1 ? WIN_P1 : win2 ? WIN_P2 : winner;
        end
    end

    pong_score_ctr #(.W(SCORE_W)) u_sc1 (
        .clk(clk), .rst(reset), .clr(start_acc), .inc(p1_pt && !deuce),
        .ld(deuce), .d(SCORE_W'(WIN_SCORE - 1)), .q(sc1)
    );
    pong_score_ctr #(.W(SCORE_W)) u_sc2 (
        .clk(clk), .rst(reset), .clr(start_acc), .inc(p2_pt && !deuce),
        .ld(deuce), .d(SCORE_W'(WIN_SCORE - 1)), .q(sc2)
    );

    assign bus.sc1        = sc1;
    assign bus.sc2        = sc2;
    assign bus.start_o    = start_o;
    assign bus.reset_game = reset_game;
    assign bus.serve_p    = serve_p;
    assign bus.winner     = winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: table vectors, directed corner sequences and random play against a match-level model.
module tb_pong_match_ctrl;
    localparam int WIN_SCORE   = 7;
    localparam int SCORE_W     = 4;
    localparam int SERVE_DELAY = 4;
    localparam int HOLD_CYCLES = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_match_ctrl_if #(.SCORE_W(SCORE_W)) bus();
    pong_match_ctrl #(
        .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W),
        .SERVE_DELAY(SERVE_DELAY), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    typedef enum int {M_ATTRACT, M_SERVE, M_RALLY, M_OVER} phase_e;
    phase_e ph;
    int left, m_s1, m_s2, m_sp, m_win, m_rg;

    typedef struct {
        logic        s, p1, p2;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[17];

    function automatic logic [12:0] pack(int s1, int s2, int so, int rg, int sp, int w);
        return {SCORE_W'(s1), SCORE_W'(s2), 1'(so), 1'(rg), 1'(sp), 2'(w)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.sc1, bus.sc2, bus.start_o, bus.reset_game, bus.serve_p, bus.winner};
    endfunction

    function automatic logic [12:0] model_vec();
        return pack(m_s1, m_s2, ph == M_ATTRACT ? 1 : 0, m_rg, m_sp, m_win);
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ph = M_ATTRACT; left = 0; m_s1 = 0; m_s2 = 0; m_sp = 0; m_win = 0; m_rg = 0;
    endfunction

    function automatic void model_step(logic s, logic p1, logic p2);
        int  pl;
        bit  won;
        m_rg = 0;
        case (ph)
            M_ATTRACT: if (s) begin
                m_s1 = 0; m_s2 = 0; m_win = 0; m_sp = 0;
                ph = M_SERVE; left = SERVE_DELAY; m_rg = 1;
            end
            M_SERVE: begin
                left--;
                if (left == 0) ph = M_RALLY;
            end
            M_RALLY: if (p1 && p2) begin
                ph = M_SERVE; left = SERVE_DELAY; m_rg = 1;
            end else if (p1 || p2) begin
                pl = p1 ? 1 : 2;
                if (pl == 1) m_s1++; else m_s2++;
                m_sp = pl - 1;
`ifdef WIN_BY_TWO_EN
                won = pl == 1 ? (m_s1 >= WIN_SCORE && m_s1 - m_s2 >= 2)
                              : (m_s2 >= WIN_SCORE && m_s2 - m_s1 >= 2);
                if (m_s1 == m_s2 && m_s1 >= WIN_SCORE) begin
                    m_s1 = WIN_SCORE - 1; m_s2 = WIN_SCORE - 1;
                end
`else
                won = (pl == 1 ? m_s1 : m_s2) == WIN_SCORE;
`endif
                if (won) begin
                    m_win = pl; ph = M_OVER; left = HOLD_CYCLES;
                end else begin
                    ph = M_SERVE; left = SERVE_DELAY; m_rg = 1;
                end
            end
            M_OVER: begin
                left--;
                if (left == 0) ph = M_ATTRACT;
            end
        endcase
    endfunction

    task automatic step(input logic s, input logic p1, input logic p2);
        bus.start = s; bus.point_p1 = p1; bus.point_p2 = p2;
        @(posedge clk);
        model_step(s, p1, p2);
        #1;
    endtask

    task automatic cycle(input logic s, input logic p1, input logic p2, input string name);
        step(s, p1, p2);
        check(name, dut_vec(), model_vec());
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1; bus.start = 1'b0; bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check(name, dut_vec(), pack(0, 0, 1, 0, 0, 0));
        reset = 1'b0;
    endtask

    task automatic to_rally();
        for (int i = 0; i < 2 * SERVE_DELAY + 2 && ph != M_RALLY; i++) cycle(1'b0, 1'b0, 1'b0, "serve_wait");
        if (ph != M_RALLY) begin
            checks++; failures++;
            $display("FAIL to_rally timeout got=%0d expected=%0d", ph, M_RALLY);
        end
    endtask

    task automatic point(input logic p1, input logic p2);
        to_rally();
        cycle(1'b0, p1, p2, "point");
    endtask

    initial begin
        int n;
        tbl[0]  = '{1, 0, 0, pack(0, 0, 0, 1, 0, 0)};
        tbl[1]  = '{0, 1, 0, pack(0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{0, 0, 1, pack(0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{0, 0, 0, pack(0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{0, 0, 0, pack(0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{0, 1, 0, pack(1, 0, 0, 1, 0, 0)};
        tbl[6]  = '{1, 0, 0, pack(1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{0, 0, 0, pack(1, 0, 0, 0, 0, 0)};
        tbl[8]  = '{0, 0, 0, pack(1, 0, 0, 0, 0, 0)};
        tbl[9]  = '{0, 0, 0, pack(1, 0, 0, 0, 0, 0)};
        tbl[10] = '{0, 0, 1, pack(1, 1, 0, 1, 1, 0)};
        tbl[11] = '{0, 1, 1, pack(1, 1, 0, 0, 1, 0)};
        tbl[12] = '{0, 0, 0, pack(1, 1, 0, 0, 1, 0)};
        tbl[13] = '{0, 0, 0, pack(1, 1, 0, 0, 1, 0)};
        tbl[14] = '{0, 0, 0, pack(1, 1, 0, 0, 1, 0)};
        tbl[15] = '{0, 1, 1, pack(1, 1, 0, 1, 1, 0)};
        tbl[16] = '{0, 0, 0, pack(1, 1, 0, 0, 1, 0)};
        reset = 1'b1; bus.start = 1'b0; bus.point_p1 = 1'b0; bus.point_p2 = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset("reset");
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].s, tbl[i].p1, tbl[i].p2);
            check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
        end
        to_rally();
        cycle(1'b1, 1'b0, 1'b0, "start_in_rally");
        for (int g = 0; g < 20 && m_win == 0; g++) point(1'b1, 1'b0);
        check("p1_win", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd7, 4'd1, 2'd1});
        n = 0;
        while (!bus.start_o && n < HOLD_CYCLES + 4) begin
            cycle(1'b1, n[0], ~n[0], "gameover_ignore");
            n++;
        end
        check("hold_len", 13'(n), 13'(HOLD_CYCLES));
        cycle(1'b0, 1'b1, 1'b0, "attract_idle");
        check("attract_keep", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd7, 4'd1, 2'd1});
        cycle(1'b1, 1'b0, 1'b0, "restart");
        check("restart_clear", dut_vec(), pack(0, 0, 0, 1, 0, 0));
`ifdef WIN_BY_TWO_EN
        for (int k = 0; k < 6; k++) begin
            point(1'b1, 1'b0);
            point(1'b0, 1'b1);
        end
        point(1'b1, 1'b0);
        check("deuce_7_6", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd7, 4'd6, 2'd0});
        point(1'b0, 1'b1);
        check("deuce_norm", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd6, 4'd6, 2'd0});
        point(1'b0, 1'b1);
        check("deuce_6_7", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd6, 4'd7, 2'd0});
        point(1'b0, 1'b1);
        check("deuce_win", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd6, 4'd8, 2'd2});
`endif
        do_reset("reset_again");
        cycle(1'b1, 1'b0, 1'b0, "start2");
        point(1'b1, 1'b0); point(1'b0, 1'b1); point(1'b1, 1'b0);
        point(1'b0, 1'b1); point(1'b1, 1'b0);
        check("score_3_2", {3'b0, bus.sc1, bus.sc2, bus.winner}, {3'b0, 4'd3, 4'd2, 2'd0});
        to_rally();
        do_reset("reset_mid_rally");
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, "random");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
